// File: rtl/obufds_drive_gen.sv
`default_nettype none
// ============================================================================
//  Module      : obufds_drive_gen
//  Description : Generates the I inputs of two differential output buffers
//                from four switches. Each lane shows either a static data
//                level or a blinking level, selected by a debounced enable
//                switch. Blink edges come from one shared prescaler tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module obufds_drive_gen #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter logic [23:0] BLINK_DIV       = 24'd10000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw,
   output logic [1:0] buf_i,
   output logic [3:0] sw_db,
   output logic [1:0] lane_blink
);

   typedef enum logic [0:0] {
      ST_STATIC = 1'b0,
      ST_BLINK  = 1'b1
   } lane_state_t;

   localparam logic [23:0] C_PRESC_LAST = BLINK_DIV - 24'd1;

   logic [3:0]  sync1_q;
   logic [3:0]  sync2_q;
   logic [23:0] presc_q;
   logic [23:0] presc_d;
   logic        tick;

   // Two-flop synchronizer; only sync2_q is used by downstream logic.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 4'b0000;
         sync2_q <= 4'b0000;
      end else begin
         sync1_q <= sw;
         sync2_q <= sync1_q;
      end
   end

   // Per-bit debouncer: sw_db adopts the synced level after it has differed
   // for DEBOUNCE_CYCLES consecutive cycles.
   for (genvar b = 0; b < 4; b++) begin : g_debounce
      logic [19:0] cnt_q;
      logic [19:0] cnt_d;
      logic        db_q;
      logic        db_d;

      // Next-state for counter and debounced level.
      always_comb begin
         cnt_d = 20'd0;
         db_d  = db_q;
         if (sync2_q[b] != db_q) begin
            if (cnt_q + 20'd1 == DEBOUNCE_CYCLES) begin
               db_d  = sync2_q[b];
               cnt_d = 20'd0;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
      end

      // Debouncer state register.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_q <= 20'd0;
            db_q  <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
         end
      end

      assign sw_db[b] = db_q;
   end

   // Free-running prescaler; never restarted by the lanes so both lanes
   // share the same blink edges.
   always_comb begin
      tick    = (presc_q == C_PRESC_LAST);
      presc_d = tick ? 24'd0 : presc_q + 24'd1;
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= 24'd0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // Per-lane STATIC/BLINK controller and registered drive bit.
   for (genvar i = 0; i < 2; i++) begin : g_lane
      lane_state_t state_q;
      lane_state_t state_d;
      logic        phase_q;
      logic        phase_d;
      logic        buf_q;
      logic        buf_d;

      // Next-state, phase and drive value; the entry edge never toggles phase.
      always_comb begin
         state_d = state_q;
         phase_d = phase_q;
         buf_d   = (state_q == ST_BLINK) ? phase_q : sw_db[2*i];
         unique case (state_q)
            ST_STATIC: begin
               if (sw_db[2*i+1]) begin
                  state_d = ST_BLINK;
                  phase_d = sw_db[2*i];
               end
            end
            ST_BLINK: begin
               if (!sw_db[2*i+1]) begin
                  state_d = ST_STATIC;
               end else if (tick) begin
                  phase_d = ~phase_q;
               end
            end
            default: state_d = ST_STATIC;
         endcase
      end

      // Lane state, phase and output register.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q <= ST_STATIC;
            phase_q <= 1'b0;
            buf_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            buf_q   <= buf_d;
         end
      end

      assign buf_i[i]      = buf_q;
      assign lane_blink[i] = (state_q == ST_BLINK);
   end

endmodule
`default_nettype wire

// File: tb/tb_obufds_drive_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obufds_drive_gen
//  Description : Self-checking bench for obufds_drive_gen with a behavioural
//                reference model (delay line, sample history, tick schedule).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_obufds_drive_gen;

   localparam int DB = 4;
   localparam int BD = 8;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw;
   logic [1:0] buf_i;
   logic [3:0] sw_db;
   logic [1:0] lane_blink;

   int n_checks;
   int n_fail;

   obufds_drive_gen #(
      .DEBOUNCE_CYCLES(20'd4),
      .BLINK_DIV      (24'd8)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw),
      .buf_i     (buf_i),
      .sw_db     (sw_db),
      .lane_blink(lane_blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   logic [3:0]  m_dly[$];
   logic [3:0]  m_hist[$];
   logic [3:0]  m_db;
   logic [1:0]  m_blink;
   logic [1:0]  m_phase;
   logic [1:0]  m_buf;
   int unsigned m_cyc;

   task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b, expected %b", tag, $time, obs, exp);
      end
   endtask

   // One clock edge of the reference model, using inputs present at the edge.
   task automatic model_edge(input logic rstn_v, input logic [3:0] sw_v);
      logic [3:0] smp;
      logic [3:0] old_db;
      logic [1:0] old_blink;
      logic [1:0] old_phase;
      logic       tick;
      logic       all_diff;
      if (!rstn_v) begin
         m_dly = {4'h0, 4'h0};
         m_hist.delete();
         m_db    = 4'h0;
         m_blink = 2'b00;
         m_phase = 2'b00;
         m_buf   = 2'b00;
         m_cyc   = 0;
         return;
      end
      // synced value seen at this edge is the raw input of two edges ago
      smp = m_dly.pop_front();
      m_dly.push_back(sw_v);
      m_hist.push_back(smp);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      old_db    = m_db;
      old_blink = m_blink;
      old_phase = m_phase;
      for (int b = 0; b < 4; b++) begin
         all_diff = (m_hist.size() == DB);
         foreach (m_hist[j]) if (m_hist[j][b] == old_db[b]) all_diff = 1'b0;
         if (all_diff) m_db[b] = ~old_db[b];
      end
      tick  = ((m_cyc % BD) == BD - 1);
      m_cyc = m_cyc + 1;
      for (int i = 0; i < 2; i++) begin
         m_buf[i] = old_blink[i] ? old_phase[i] : old_db[2*i];
         if (!old_blink[i]) begin
            if (old_db[2*i+1]) begin
               m_blink[i] = 1'b1;
               m_phase[i] = old_db[2*i];
            end
         end else if (!old_db[2*i+1]) begin
            m_blink[i] = 1'b0;
         end else if (tick) begin
            m_phase[i] = ~old_phase[i];
         end
      end
   endtask

   task automatic step(input logic rstn_v, input logic [3:0] sw_v);
      rst_n = rstn_v;
      sw    = sw_v;
      @(posedge clk);
      model_edge(rstn_v, sw_v);
      #1;
      check_eq("sw_db", sw_db, m_db);
      check_eq("buf_i", {2'b00, buf_i}, {2'b00, m_buf});
      check_eq("lane_blink", {2'b00, lane_blink}, {2'b00, m_blink});
   endtask

   task automatic hold(input logic [3:0] sw_v, input int n);
      for (int k = 0; k < n; k++) step(1'b1, sw_v);
   endtask

   initial begin
      logic [3:0] v;
      int         len;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      sw       = 4'h0;
      m_dly    = {4'h0, 4'h0};

      // reset with switches active: outputs must stay cleared
      step(1'b0, 4'hF);
      step(1'b0, 4'hF);
      step(1'b0, 4'h0);
      // static data on lane 0
      hold(4'b0001, 10);
      hold(4'b0000, 10);
      // short glitch is filtered
      hold(4'b0001, 3);
      hold(4'b0000, 10);
      // lane 0 blinking with data 1
      hold(4'b0011, 30);
      // data toggles during blink must not disturb phase
      hold(4'b0010, 7);
      hold(4'b0011, 9);
      // leave blink
      hold(4'b0001, 12);
      // both lanes blinking, then lane 1 back to static
      hold(4'b1010, 30);
      hold(4'b0010, 20);
      // reset mid-blink, then re-debounce
      step(1'b0, 4'b0010);
      hold(4'b0010, 30);

      // randomized segments with occasional resets
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 29) == 0) begin
            step(1'b0, 4'($urandom));
         end else begin
            v   = 4'($urandom);
            len = $urandom_range(1, 14);
            hold(v, len);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
